// File: rtl/gpr_read_file.sv
// gpr_read_file: 2**AW x DW register file with two async read ports,
// one write port, write-back bypass and a pending-write scoreboard.
// Ports: clk (state on falling edge), rst (async, active-high),
//   re1/raddr1/rdata1, re2/raddr2/rdata2 : read ports (re* qualify stall)
//   we/waddr/wdata                        : write-back write port
//   iss_en/iss_addr                       : decode destination issue
//   stall                                 : enabled read hits a pending reg
//   busy_vec                              : scoreboard bits
module gpr_read_file #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re1,
  input  logic [AW-1:0]     raddr1,
  output logic [DW-1:0]     rdata1,
  input  logic              re2,
  input  logic [AW-1:0]     raddr2,
  output logic [DW-1:0]     rdata2,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              stall,
  output logic [(1<<AW)-1:0] busy_vec
);

  localparam int NR = 1 << AW;

  logic [DW-1:0] regs_q [NR];
  logic [NR-1:0] busy_q;
  logic [NR-1:0] busy_d;

  logic          wr_ok;
  logic          iss_ok;
  logic          byp1;
  logic          byp2;
  logic          hit1;
  logic          hit2;

  assign wr_ok  = we && (waddr != '0);
  assign iss_ok = iss_en && (iss_addr != '0);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Issue is applied after the write clear: a same-address issue marks a
  // newer producer that must stay pending.
  always_comb begin
    busy_d = busy_q;
    if (wr_ok) begin
      busy_d[waddr] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign byp1 = we && (waddr == raddr1);
  assign byp2 = we && (waddr == raddr2);

  // Reads are gated by rst so the bypass cannot leak data during reset.
  always_comb begin
    rdata1 = '0;
    if (!rst && (raddr1 != '0)) begin
      rdata1 = byp1 ? wdata : regs_q[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (!rst && (raddr2 != '0)) begin
      rdata2 = byp2 ? wdata : regs_q[raddr2];
    end
  end

  // The producer's own write-back cycle cancels its stall via the bypass.
  assign hit1 = re1 && (raddr1 != '0) && busy_q[raddr1] && !byp1;
  assign hit2 = re2 && (raddr2 != '0) && busy_q[raddr2] && !byp2;

  assign stall    = hit1 | hit2;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_gpr_read_file.sv
// tb_gpr_read_file: directed self-checking bench for gpr_read_file.
// Inputs change 1ns after each falling edge; checks follow 1ns later.
module tb_gpr_read_file;

  logic        clk;
  logic        rst;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic        stall;
  logic [31:0] busy_vec;

  int checks;
  int failures;

  gpr_read_file #(.DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
    .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
    .we(we), .waddr(waddr), .wdata(wdata),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .stall(stall), .busy_vec(busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; iss_en = 0; re1 = 0; re2 = 0;
    waddr = 0; wdata = 0; iss_addr = 0;
  endtask

  task automatic test_reset();
    idle();
    we = 1; waddr = 5; wdata = 32'hDEADBEEF;
    iss_en = 1; iss_addr = 5;
    tick();
    idle();
    raddr1 = 5; re1 = 1;
    #1;
    checks++;
    if (rdata1 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rst_pre_data got=%h exp=%h", rdata1, 32'hDEADBEEF);
    end
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_stall got=%b exp=1", stall);
    end
    // reset mid-operation, between edges, with a write and issue pending
    we = 1; waddr = 5; wdata = 32'hCAFEF00D;
    iss_en = 1; iss_addr = 6;
    rst = 1;
    #1;
    checks++;
    if (rdata1 !== 32'h0) begin
      failures++;
      $display("FAIL rst_data got=%h exp=0", rdata1);
    end
    checks++;
    if (busy_vec !== 32'h0) begin
      failures++;
      $display("FAIL rst_busy got=%h exp=0", busy_vec);
    end
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_stall got=%b exp=0", stall);
    end
    tick();
    rst = 0;
    idle();
    re1 = 1; raddr1 = 5;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || busy_vec !== 32'h0) begin
      failures++;
      $display("FAIL rst_dominates data=%h busy=%h exp=0/0",
               rdata1, busy_vec);
    end
  endtask

  task automatic test_r0();
    idle();
    we = 1; waddr = 0; wdata = 32'h12345678;
    iss_en = 1; iss_addr = 0;
    re1 = 1; raddr1 = 0;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL r0_pre data=%h stall=%b exp=0/0", rdata1, stall);
    end
    tick();
    checks++;
    if (rdata1 !== 32'h0 || busy_vec !== 32'h0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL r0_post data=%h busy=%h stall=%b exp=0/0/0",
               rdata1, busy_vec, stall);
    end
    idle();
  endtask

  task automatic test_bypass();
    idle();
    we = 1; waddr = 7; wdata = 32'h11111111;
    tick();
    idle();
    raddr2 = 7;
    #1;
    checks++;
    if (rdata2 !== 32'h11111111) begin
      failures++;
      $display("FAIL wr_r7 got=%h exp=11111111", rdata2);
    end
    we = 1; waddr = 7; wdata = 32'hA5A5A5A5;
    #1;
    checks++;
    if (rdata2 !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL bypass got=%h exp=a5a5a5a5", rdata2);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rdata2 !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL bypass_held got=%h exp=a5a5a5a5", rdata2);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    iss_en = 1; iss_addr = 9;
    tick();
    idle();
    re1 = 1; raddr1 = 9;
    #1;
    checks++;
    if (busy_vec !== 32'h0000_0200 || stall !== 1'b1) begin
      failures++;
      $display("FAIL sb_issue busy=%h stall=%b exp=00000200/1",
               busy_vec, stall);
    end
    we = 1; waddr = 9; wdata = 32'h42;
    #1;
    checks++;
    if (stall !== 1'b0 || rdata1 !== 32'h42) begin
      failures++;
      $display("FAIL sb_wb stall=%b data=%h exp=0/42", stall, rdata1);
    end
    tick();
    idle();
    re1 = 1; raddr1 = 9;
    #1;
    checks++;
    if (busy_vec[9] !== 1'b0 || stall !== 1'b0 || rdata1 !== 32'h42) begin
      failures++;
      $display("FAIL sb_clear busy9=%b stall=%b data=%h exp=0/0/42",
               busy_vec[9], stall, rdata1);
    end
    iss_en = 1; iss_addr = 9;
    tick();
    idle();
    re1 = 0; raddr1 = 9;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL sb_re_off got=%b exp=0", stall);
    end
    re1 = 1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL sb_re_on got=%b exp=1", stall);
    end
    we = 1; waddr = 9; wdata = 32'h42;
    tick();
    idle();
  endtask

  task automatic test_same_edge();
    idle();
    iss_en = 1; iss_addr = 3;
    tick();
    idle();
    iss_en = 1; iss_addr = 3;
    we = 1; waddr = 3; wdata = 32'h7;
    tick();
    idle();
    re2 = 1; raddr2 = 3;
    #1;
    checks++;
    if (rdata2 !== 32'h7 || busy_vec[3] !== 1'b1 || stall !== 1'b1) begin
      failures++;
      $display("FAIL same_addr data=%h busy3=%b stall=%b exp=7/1/1",
               rdata2, busy_vec[3], stall);
    end
    iss_en = 1; iss_addr = 4;
    we = 1; waddr = 3; wdata = 32'h8;
    tick();
    idle();
    #1;
    checks++;
    if (busy_vec !== 32'h0000_0010) begin
      failures++;
      $display("FAIL diff_addr busy=%h exp=00000010", busy_vec);
    end
    we = 1; waddr = 4; wdata = 32'h0;
    tick();
    idle();
  endtask

  task automatic test_dual_port();
    idle();
    we = 1; waddr = 1; wdata = 32'h1;
    tick();
    we = 1; waddr = 2; wdata = 32'h2;
    tick();
    idle();
    iss_en = 1; iss_addr = 2;
    tick();
    idle();
    re1 = 1; raddr1 = 1;
    re2 = 1; raddr2 = 2;
    #1;
    checks++;
    if (rdata1 !== 32'h1 || rdata2 !== 32'h2 || stall !== 1'b1) begin
      failures++;
      $display("FAIL dual d1=%h d2=%h stall=%b exp=1/2/1",
               rdata1, rdata2, stall);
    end
    checks++;
    if (busy_vec !== 32'h0000_0004) begin
      failures++;
      $display("FAIL dual_busy got=%h exp=00000004", busy_vec);
    end
    re2 = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL dual_re2_off got=%b exp=0", stall);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1;
    re1 = 0; re2 = 0; raddr1 = 0; raddr2 = 0;
    we = 0; waddr = 0; wdata = 0;
    iss_en = 0; iss_addr = 0;
    #1;
    checks++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0 ||
        busy_vec !== 32'h0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL init_reset d1=%h d2=%h busy=%h stall=%b exp=0",
               rdata1, rdata2, busy_vec, stall);
    end
    tick();
    tick();
    rst = 0;
    test_reset();
    test_r0();
    test_bypass();
    test_scoreboard();
    test_same_edge();
    test_dual_port();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpr_read_file.md
Name: gpr_read_file

Overview:
- 32 x 32-bit general-purpose register file for the P4 datapath.
- It is the read side of the storage written by the write-back stage: two asynchronous read ports, one write port, and a per-register pending-write scoreboard.
- The scoreboard raises a stall when a requested operand still has an outstanding producer.
- It sits between decode (reads, destination issue) and write-back (writes).

Parameters:
- DW, 32, data width of each register.
- AW, 5, address width; register count is 2**AW.

Ports:
- clk  input  1  system clock; all state updates on the falling edge.
- rst  input  1  asynchronous, active-high reset.
- re1  input  1  read port 1 in use (qualifies stall only).
- raddr1  input  AW  read port 1 address.
- rdata1  output  DW  read port 1 data.
- re2  input  1  read port 2 in use.
- raddr2  input  AW  read port 2 address.
- rdata2  output  DW  read port 2 data.
- we  input  1  write enable from write-back.
- waddr  input  AW  write address.
- wdata  input  DW  write data.
- iss_en  input  1  decode issues an instruction with a destination register.
- iss_addr  input  AW  destination register being issued.
- stall  output  1  an enabled read port targets a pending register.
- busy_vec  output  2**AW  scoreboard bits, for debug and verification.

Behaviour:
- Reset (asynchronous, active-high):
  - All registers clear to 0 and all busy bits clear to 0 immediately, independent of clk.
  - Outputs during reset: rdata1 = rdata2 = 0, stall = 0, busy_vec = 0.
- Write:
  - On the falling edge of clk with rst = 0, if we = 1 and waddr != 0, then reg[waddr] <= wdata.
  - Writes to register 0 are discarded; register 0 always reads 0.
- Read:
  - Combinational, zero latency.
  - rdata1 = 0 if raddr1 == 0.
  - Otherwise rdata1 = wdata if (we && waddr == raddr1); this bypass makes same-cycle write data visible before the edge.
  - Otherwise rdata1 = reg[raddr1]. Port 2 behaves identically.
  - re1 and re2 do not gate rdata.
- Scoreboard (updated on the falling edge, rst = 0):
  - iss_en = 1 and iss_addr != 0: busy[iss_addr] <= 1.
  - we = 1 and waddr != 0: busy[waddr] <= 0, unless the issue rule sets the same bit on the same edge.
  - Issue and write to the same address on the same edge: the bit stays 1, because a newer producer is pending. The data write still occurs.
  - Issue and write to different addresses on the same edge: both updates apply.
  - busy[0] is constantly 0.
- Stall (combinational):
  - hit1 = re1 && raddr1 != 0 && busy[raddr1] && !(we && waddr == raddr1). hit2 is defined likewise for port 2.
  - stall = hit1 | hit2.
  - The write-back bypass cancels the stall in the cycle the producer writes.
- Write to a non-busy register: legal; data updates and busy remains 0.
- Reset mid-operation (rst asserted while we or iss_en is high): reset dominates; nothing is written; all state returns to 0.
- No wrap or overflow conditions exist. Addresses are full-range and all 2**AW entries are valid.

Test Plan:
- Reset clears state: write 0xDEADBEEF to r5, then pulse rst asynchronously between clock edges.
  -> rdata1(r5) = 0 immediately; busy_vec = 0; stall = 0.
- Register 0 is hardwired: we = 1, waddr = 0, wdata = 0x12345678, iss_en = 1, iss_addr = 0.
  -> rdata1(r0) = 0 before and after the edge; busy_vec[0] = 0; stall = 0 with re1 = 1.
- Write and bypass:
  - Hold r7 = 0x11111111, then set we = 1, waddr = 7, wdata = 0xA5A5A5A5, raddr2 = 7 -> rdata2 = 0xA5A5A5A5 before the falling edge.
  - Drop we after the edge -> rdata2 stays 0xA5A5A5A5.
- Scoreboard stall lifecycle:
  - Issue r9 -> busy_vec[9] = 1 after the edge; re1 = 1, raddr1 = 9 -> stall = 1.
  - Next cycle we = 1, waddr = 9, wdata = 0x00000042 -> stall = 0 combinationally and rdata1 = 0x42; busy_vec[9] = 0 after the edge.
  - With re1 = 0 and r9 busy -> stall = 0.
- Same-edge issue and write to r3:
  - r3 busy; iss_en = 1, iss_addr = 3, we = 1, waddr = 3, wdata = 0x7.
  - -> after the edge reg[3] = 0x7 and busy_vec[3] = 1; a subsequent read of r3 with re2 = 1 gives stall = 1.
- Dual-port independence: r1 = 0x1, r2 = 0x2, r2 busy; re1 = re2 = 1, raddr1 = 1, raddr2 = 2.
  -> rdata1 = 0x1, rdata2 = 0x2, stall = 1.
  - Clear port 2 (re2 = 0) -> stall = 0.
